// File: rtl/core_pkg.sv
// Shared types and constants for the femtoRV32 fetch sequencing logic.
package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      TRAP = 2'd2
   } pcseq_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target for the EX instruction plus its word-alignment check.
// Purely combinational, no backpressure.
module pc_target_calc
   import core_pkg::*;
(
   input  logic            ex_is_jalr,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;

   assign base = ex_is_jalr ? ex_rs1 : ex_pc;
   assign sum  = base + ex_imm;

   // JALR drops bit 0; for JAL/branches bit 0 is already zero by encoding.
   assign target     = ex_is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
   assign misaligned = target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential step, EX redirect (1-cycle, 2-cycle penalty), stall hold,
// halt and misaligned-target trap; stall freezes pc but never blocks a redirect.
module pc_sequencer
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_should_jump,
   input  logic             ex_is_jalr,
   input  logic             ex_halt,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic             resume,
   output logic [XLEN-1:0]  pc,
   output logic             fetch_valid,
   output logic             flush,
   output logic             halted,
   output logic             trap,
   output logic [CNT_W-1:0] redirect_count
);

   pcseq_state_t     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  target;
   logic             misaligned;
   logic             flush_c;

   pc_target_calc u_target (
      .ex_is_jalr (ex_is_jalr),
      .ex_pc      (ex_pc),
      .ex_imm     (ex_imm),
      .ex_rs1     (ex_rs1),
      .target     (target),
      .misaligned (misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      flush_c = 1'b0;
      unique case (state_q)
         RUN: begin
            // Redirects win over stall: the stalled younger slots are squashed anyway.
            if (ex_valid && ex_halt) begin
               pc_d    = ex_pc + PC_INC;
               state_d = HALT;
               flush_c = 1'b1;
            end else if (ex_valid && ex_should_jump && misaligned) begin
               pc_d    = ex_pc;
               state_d = TRAP;
               flush_c = 1'b1;
            end else if (ex_valid && ex_should_jump) begin
               pc_d    = target;
               cnt_d   = cnt_q + CNT_W'(1);
               flush_c = 1'b1;
            end else if (!stall) begin
               pc_d = pc_q + PC_INC;
            end
         end
         HALT, TRAP: begin
            if (resume) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc             = pc_q;
   assign flush          = flush_c && !rst;
   assign fetch_valid    = (state_q == RUN) && !stall && !rst;
   assign halted         = (state_q == HALT);
   assign trap           = (state_q == TRAP);
   assign redirect_count = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the fetch program counter of the pipelined femtoRV32 core and sequences every change to it: sequential increment, taken branch/jump redirect, stall hold, halt and misaligned-target trap. It consumes the taken/not-taken decision and operands of the instruction in EX. It drives the fetch address, the squash (flush) of the two younger pipeline registers, and a small performance counter. It sits between the EX-stage jump decision logic and the IF stage, alongside the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `CNT_W`, default 32: width of the redirect counter.

- `clk` in 1: single core clock.
- `rst` in 1: reset, synchronous and active-high.
- `stall` in 1: hazard-unit hold request (load-use); PC and fetch hold.
- `ex_valid` in 1: EX holds a real (non-bubble) instruction.
- `ex_should_jump` in 1: taken decision for the EX instruction (branch taken or JAL/JALR).
- `ex_is_jalr` in 1: EX instruction is JALR.
- `ex_halt` in 1: EX instruction is ECALL/EBREAK (core halt).
- `ex_pc` in 32: PC of the EX instruction.
- `ex_imm` in 32: sign-extended immediate of the EX instruction.
- `ex_rs1` in 32: forwarded rs1 value of the EX instruction.
- `resume` in 1: debug restart from HALT/TRAP.
- `pc` out 32: fetch address.
- `fetch_valid` out 1: IF should issue a fetch this cycle.
- `flush` out 1: clear IF/ID and ID/EX at the next edge.
- `halted` out 1: state is HALT.
- `trap` out 1: state is TRAP (misaligned target).
- `redirect_count` out CNT_W: number of taken redirects since reset.

## Operation
- FSM states: RUN, HALT, TRAP. Reset → RUN.
- Target: JALR → (ex_rs1 + ex_imm) & ~32'h1; else ex_pc + ex_imm. Mod-2^32 wrap, no overflow detection.
- Misaligned: target[1] == 1. There is no C extension, so bit 0 is already cleared for JALR and is 0 by encoding for the others.
- RUN priority, highest first, each gated by ex_valid where an EX event is involved:
  1. ex_halt → pc ← ex_pc + 4, state ← HALT, flush = 1.
  2. ex_should_jump with misaligned target → pc ← ex_pc, state ← TRAP, flush = 1.
  3. ex_should_jump → pc ← target, flush = 1, redirect_count += 1 (wraps).
  4. stall → pc holds, flush = 0.
  5. Otherwise → pc ← pc + 4.
- A redirect overrides a simultaneous stall, because the stalled younger instructions are squashed anyway.
- HALT and TRAP: pc holds, fetch_valid = 0, flush = 0, EX inputs are ignored.
- resume in HALT or TRAP → RUN at the next edge; fetch restarts from the held pc.
- resume in RUN has no effect.
- rst overrides everything, including in mid-redirect or in HALT.

## Timing
- Reset values: pc = RESET_PC, state RUN, redirect_count = 0, trap = 0, halted = 0.
- flush is combinational (state + EX inputs) and is forced 0 while rst = 1.
- fetch_valid = (state == RUN) && !stall && !rst.
- Redirect: the decision arrives in cycle N; pc = target in cycle N+1; the IF/ID and ID/EX contents from cycle N are cleared at the N→N+1 edge. Taken-branch penalty is 2 cycles.
- Not-taken branch: zero penalty; pc + 4 continues.
- halted and trap are registered: they assert the cycle after the causing event and deassert the cycle after resume.
- pc + 4 at 32'hFFFF_FFFC wraps to 0.

## Structure
- Shared package `core_pkg`:
  - `pcseq_state_t` enum {RUN, HALT, TRAP}
  - `PC_INC` = 4
  - `XLEN` = 32
- One combinational sub-module, `pc_target_calc`: computes target and misaligned from ex_is_jalr, ex_pc, ex_imm and ex_rs1.
- The FSM, PC register and counter stay in `pc_sequencer`.

## Test plan
- Reset: rst high 2 cycles with RESET_PC = 32'h100 → pc = 32'h100, redirect_count = 0, flush = 0; after release, pc steps 104, 108.
- Taken branch: ex_valid = 1, ex_should_jump = 1, ex_pc = 32'h200, ex_imm = 32'hFFFF_FFF0 → flush = 1 that cycle, next pc = 32'h1F0, redirect_count = 1.
- JALR with stall: ex_rs1 = 32'h1001, ex_imm = 3, is_jalr = 1, stall = 1 simultaneously → pc = 32'h1004 (LSB cleared), flush = 1, stall ignored.
- Misaligned: JAL with ex_pc = 32'h40, ex_imm = 6 → trap = 1 next cycle, pc = 32'h40, fetch_valid = 0; resume → RUN, fetch from 32'h40.
- Halt then reset: ECALL at ex_pc = 32'h80 → halted = 1, pc = 32'h84, fetch_valid = 0; rst → pc = RESET_PC, halted = 0.
- Bubble: ex_valid = 0 with ex_should_jump = 1 → no flush, pc + 4, counter unchanged.
